// File: rtl/aes_pkg.sv
// Shared definitions for the AES byte-to-beat frame packer.
package aes_pkg;

  // Frame packer FSM: two byte-collection phases, then two output beats.
  typedef enum logic [1:0] {
    COLLECT_TEXT = 2'd0,
    COLLECT_KEY  = 2'd1,
    SEND_TEXT    = 2'd2,
    SEND_KEY     = 2'd3
  } packer_state_t;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_FRAME_BEATS = 2;
  localparam int AES_ID_W        = 32;

  // True when the byte counter points at the last byte of a 16-byte half.
  function automatic logic is_last_byte(input logic [3:0] cnt);
    return (cnt == 4'(AES_BLOCK_BYTES - 1));
  endfunction

endpackage

// File: rtl/aes_frame_packer_byte_shift128.sv
// 16-byte left shift register: the first byte loaded ends up in the MSB lane.
module byte_shift128
  import aes_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_clr,
  input  logic                           i_en,
  input  logic [7:0]                     i_byte,
  output logic [AES_BLOCK_BYTES*8-1:0]   o_q
);

  logic [AES_BLOCK_BYTES*8-1:0] r_q;

  // Shift a new byte into the LSB lane; clear has priority over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 128'd0;
    end else if (i_clr) begin
      r_q <= 128'd0;
    end else if (i_en) begin
      r_q <= {r_q[AES_BLOCK_BYTES*8-9:0], i_byte};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/aes_frame_packer.sv
// Collects 32-byte frames (16 text + 16 key) and emits them as a text beat
// followed by a key beat (tlast) towards the aes core, tagged with a frame id.
module aes_frame_packer
  import aes_pkg::*;
#(
  parameter logic [AES_ID_W-1:0] ID_START       = 32'd1,
  parameter int unsigned         TIMEOUT_CYCLES = 32'd1024
)(
  input  logic                  clk_out,
  input  logic                  srst_n,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  tvalid,
  output logic                  tlast,
  input  logic                  tready,
  output logic [AES_ID_W-1:0]   tid,
  output logic [127:0]          tdata,
  output logic                  frame_err,
  output logic                  busy
);

  // A zero timeout still needs a legal one-bit counter; it is simply never armed.
  localparam int          IDLE_W      = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
  localparam int unsigned IDLE_LAST_I = (TIMEOUT_CYCLES > 32'd0) ? TIMEOUT_CYCLES - 32'd1 : 32'd0;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LAST_I);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);

  packer_state_t         r_state;
  packer_state_t         w_state_next;
  logic [3:0]            r_byte_cnt;
  logic [3:0]            w_byte_cnt_next;
  logic [IDLE_W-1:0]     r_idle_cnt;
  logic [IDLE_W-1:0]     w_idle_next;
  logic [AES_ID_W-1:0]   r_tid;
  logic [AES_ID_W-1:0]   w_tid_next;
  logic                  r_frame_err;
  logic                  w_frame_err_next;

  logic                  w_collect;
  logic                  w_accept;
  logic                  w_timeout_armed;
  logic                  w_timeout_hit;
  logic                  w_text_en;
  logic                  w_key_en;
  logic                  w_clr;
  logic [127:0]          w_text_q;
  logic [127:0]          w_key_q;

  assign w_collect       = (r_state == COLLECT_TEXT) || (r_state == COLLECT_KEY);
  assign w_accept        = s_valid && w_collect;
  // The timeout only guards a frame that has actually started.
  assign w_timeout_armed = ((r_state == COLLECT_TEXT) && (r_byte_cnt != 4'd0)) ||
                           (r_state == COLLECT_KEY);
  // Fires on the edge that would complete TIMEOUT_CYCLES idle cycles.
  assign w_timeout_hit   = (TIMEOUT_CYCLES != 32'd0) && w_timeout_armed &&
                           (r_idle_cnt == IDLE_LAST);

  byte_shift128 u_text_sr (
    .clk    (clk_out),
    .rst_n  (srst_n),
    .i_clr  (w_clr),
    .i_en   (w_text_en),
    .i_byte (s_data),
    .o_q    (w_text_q)
  );

  byte_shift128 u_key_sr (
    .clk    (clk_out),
    .rst_n  (srst_n),
    .i_clr  (w_clr),
    .i_en   (w_key_en),
    .i_byte (s_data),
    .o_q    (w_key_q)
  );

  // Next-state, counters, id and load/clear strobes.
  always_comb begin
    w_state_next     = r_state;
    w_byte_cnt_next  = r_byte_cnt;
    w_idle_next      = IDLE_ZERO;
    w_tid_next       = r_tid;
    w_frame_err_next = 1'b0;
    w_text_en        = 1'b0;
    w_key_en         = 1'b0;
    w_clr            = 1'b0;
    case (r_state)
      COLLECT_TEXT, COLLECT_KEY: begin
        if (w_accept) begin
          // An accepted byte always wins over a simultaneous timeout.
          w_byte_cnt_next = r_byte_cnt + 4'd1;
          w_idle_next     = IDLE_ZERO;
          if (r_state == COLLECT_TEXT) begin
            w_text_en = 1'b1;
          end else begin
            w_key_en  = 1'b1;
          end
          if (is_last_byte(r_byte_cnt)) begin
            w_state_next = (r_state == COLLECT_TEXT) ? COLLECT_KEY : SEND_TEXT;
          end else begin
            w_state_next = r_state;
          end
        end else if (w_timeout_hit) begin
          w_state_next     = COLLECT_TEXT;
          w_byte_cnt_next  = 4'd0;
          w_idle_next      = IDLE_ZERO;
          w_frame_err_next = 1'b1;
          w_clr            = 1'b1;
        end else if (w_timeout_armed) begin
          w_idle_next = r_idle_cnt + IDLE_ONE;
        end else begin
          w_idle_next = IDLE_ZERO;
        end
      end
      SEND_TEXT: begin
        if (tready) begin
          w_state_next = SEND_KEY;
        end else begin
          w_state_next = SEND_TEXT;
        end
      end
      SEND_KEY: begin
        if (tready) begin
          w_state_next = COLLECT_TEXT;
          w_tid_next   = r_tid + 32'd1;
          w_clr        = 1'b1;
        end else begin
          w_state_next = SEND_KEY;
        end
      end
      default: begin
        w_state_next    = COLLECT_TEXT;
        w_byte_cnt_next = 4'd0;
      end
    endcase
  end

  // State, counters, frame id and error pulse registers.
  always_ff @(posedge clk_out or negedge srst_n) begin
    if (!srst_n) begin
      r_state     <= COLLECT_TEXT;
      r_byte_cnt  <= 4'd0;
      r_idle_cnt  <= IDLE_ZERO;
      r_tid       <= ID_START;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_byte_cnt  <= w_byte_cnt_next;
      r_idle_cnt  <= w_idle_next;
      r_tid       <= w_tid_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  // Output decode from the state register; payload muxed by beat.
  always_comb begin
    s_ready = 1'b0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    tdata   = 128'd0;
    case (r_state)
      COLLECT_TEXT: s_ready = 1'b1;
      COLLECT_KEY:  s_ready = 1'b1;
      SEND_TEXT: begin
        tvalid = 1'b1;
        tdata  = w_text_q;
      end
      SEND_KEY: begin
        tvalid = 1'b1;
        tlast  = 1'b1;
        tdata  = w_key_q;
      end
      default: begin
        s_ready = 1'b0;
        tvalid  = 1'b0;
      end
    endcase
  end

  assign tid       = r_tid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != COLLECT_TEXT) || (r_byte_cnt != 4'd0);

endmodule
